// File: rtl/bus_dev_fifo_if.sv
// rtl/bus_dev_fifo_if.sv - bus-side pending/pop/push handshake bundle
interface bus_dev_fifo_if #(
    parameter int pckg_sz = 16
) ();
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

// File: rtl/bus_dev_fifo.sv
// rtl/bus_dev_fifo.sv - bus device endpoint with host TX FIFO and address-filtered RX FIFO
module bus_dev_fifo #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    bus_dev_fifo_if.slave      bus,
    input  logic               host_push,
    input  logic [pckg_sz-1:0] host_wdata,
    output logic               tx_full,
    input  logic               host_pop,
    output logic [pckg_sz-1:0] host_rdata,
    output logic               rx_empty,
    output logic [7:0]         rx_drops,
    output logic               err
);
    localparam int aw = $clog2(depth);
    localparam logic [aw-1:0] ptr_one  = 1;
    localparam logic [aw:0]   cnt_one  = 1;
    localparam logic [aw:0]   cnt_full = (aw + 1)'(depth);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [aw-1:0]      tx_rd, tx_wr, rx_rd, rx_wr;
    logic [aw:0]        tx_cnt, rx_cnt;

    logic tx_is_empty, tx_is_full, rx_is_empty, rx_is_full;
    logic tx_do_pop, tx_do_push, rx_match, rx_acc, rx_do_pop, rx_do_push, rx_drop;

    assign tx_is_empty = (tx_cnt == '0);
    assign tx_is_full  = (tx_cnt == cnt_full);
    assign rx_is_empty = (rx_cnt == '0);
    assign rx_is_full  = (rx_cnt == cnt_full);

    // A write into a full FIFO is only room-safe when the head leaves in the same cycle.
    assign tx_do_pop  = bus.pop && !tx_is_empty;
    assign tx_do_push = host_push && (!tx_is_full || tx_do_pop);

    assign rx_match   = (bus.D_push[pckg_sz-1 -: 8] == id) || (bus.D_push[pckg_sz-1 -: 8] == broadcast);
    assign rx_acc     = bus.push && rx_match;
    assign rx_do_pop  = host_pop && !rx_is_empty;
    assign rx_do_push = rx_acc && (!rx_is_full || rx_do_pop);
    assign rx_drop    = rx_acc && rx_is_full && !rx_do_pop;

    // Storage arrays carry no reset; the counts mask stale entries on the outputs.
    always_ff @(posedge clk) begin
        if (reset && tx_do_push) tx_mem[tx_wr] <= host_wdata;
        if (reset && rx_do_push) rx_mem[rx_wr] <= bus.D_push;
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_rd  <= '0;
            tx_wr  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_do_pop)  tx_rd <= tx_rd + ptr_one;
            if (tx_do_push) tx_wr <= tx_wr + ptr_one;
            case ({tx_do_push, tx_do_pop})
                2'b10:   tx_cnt <= tx_cnt + cnt_one;
                2'b01:   tx_cnt <= tx_cnt - cnt_one;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX pointers, occupancy and saturating overflow counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_rd    <= '0;
            rx_wr    <= '0;
            rx_cnt   <= '0;
            rx_drops <= '0;
        end else begin
            if (rx_do_pop)  rx_rd <= rx_rd + ptr_one;
            if (rx_do_push) rx_wr <= rx_wr + ptr_one;
            case ({rx_do_push, rx_do_pop})
                2'b10:   rx_cnt <= rx_cnt + cnt_one;
                2'b01:   rx_cnt <= rx_cnt - cnt_one;
                default: rx_cnt <= rx_cnt;
            endcase
            if (rx_drop && rx_drops != 8'hFF) rx_drops <= rx_drops + 8'd1;
        end
    end

    // Sticky underflow flag for either side reading an empty FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((bus.pop && tx_is_empty) || (host_pop && rx_is_empty)) begin
            err <= 1'b1;
        end
    end

    assign bus.pndng  = !tx_is_empty;
    assign bus.D_pop  = tx_is_empty ? '0 : tx_mem[tx_rd];
    assign tx_full    = tx_is_full;
    assign rx_empty   = rx_is_empty;
    assign host_rdata = rx_is_empty ? '0 : rx_mem[rx_rd];
endmodule

// File: tb/tb_bus_dev_fifo.sv
// tb/tb_bus_dev_fifo.sv - self-checking bench for bus_dev_fifo with queue-based reference model
module tb_bus_dev_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_push = 1'b0;
    logic [15:0] host_wdata = '0;
    logic        tx_full;
    logic        host_pop = 1'b0;
    logic [15:0] host_rdata;
    logic        rx_empty;
    logic [7:0]  rx_drops;
    logic        err;

    bus_dev_fifo_if #(.pckg_sz(16)) bif ();

    bus_dev_fifo #(.pckg_sz(16), .depth(DEPTH), .id(8'd3), .broadcast(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bif),
        .host_push  (host_push),
        .host_wdata (host_wdata),
        .tx_full    (tx_full),
        .host_pop   (host_pop),
        .host_rdata (host_rdata),
        .rx_empty   (rx_empty),
        .rx_drops   (rx_drops),
        .err        (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    int          m_drops = 0;
    bit          m_err = 1'b0;

    // Reference model: two bounded queues updated from the inputs seen at each rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txq.delete();
            rxq.delete();
            m_drops = 0;
            m_err = 1'b0;
        end else begin
            if (bif.pop) begin
                if (txq.size() == 0) m_err = 1'b1;
                else void'(txq.pop_front());
            end
            if (host_push && txq.size() < DEPTH) txq.push_back(host_wdata);
            if (host_pop) begin
                if (rxq.size() == 0) m_err = 1'b1;
                else void'(rxq.pop_front());
            end
            if (bif.push && (bif.D_push[15:8] == 8'd3 || bif.D_push[15:8] == 8'hFF)) begin
                if (rxq.size() < DEPTH) rxq.push_back(bif.D_push);
                else if (m_drops < 255) m_drops++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [43:0] act, expv;
        if (run) begin
            act  = {bif.pndng, bif.D_pop, tx_full, rx_empty, host_rdata, rx_drops, err};
            expv = {txq.size() != 0, (txq.size() != 0) ? txq[0] : 16'h0, txq.size() == DEPTH,
                    rxq.size() == 0, (rxq.size() != 0) ? rxq[0] : 16'h0, 8'(m_drops), m_err};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL model_cmp t=%0t got %h expected %h", $time, act, expv);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic drive(input logic hp, input logic [15:0] hw, input logic p,
                         input logic ps, input logic [15:0] dp, input logic hpo);
        host_push = hp; host_wdata = hw; bif.pop = p;
        bif.push = ps; bif.D_push = dp; host_pop = hpo;
        @(posedge clk); #1;
        host_push = 1'b0; host_wdata = '0; bif.pop = 1'b0;
        bif.push = 1'b0; bif.D_push = '0; host_pop = 1'b0;
    endtask

    initial begin
        bif.pop = 1'b0; bif.push = 1'b0; bif.D_push = '0;
        #1 reset = 1'b0;
        host_push = 1'b1; host_wdata = 16'h1234; bif.push = 1'b1; bif.D_push = 16'h03AA;
        #1 run = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_pndng", 16'(bif.pndng), 16'h0);
        chk("reset_rx_empty", 16'(rx_empty), 16'h1);
        chk("reset_err", 16'(err), 16'h0);
        host_push = 1'b0; host_wdata = '0; bif.push = 1'b0; bif.D_push = '0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("post_reset_nothing_stored", 16'(bif.pndng), 16'h0);

        for (int i = 1; i <= 8; i++) drive(1, 16'(i), 0, 0, 0, 0);
        chk("tx_full_after_8", 16'(tx_full), 16'h1);
        chk("tx_head_first", bif.D_pop, 16'h0001);
        drive(1, 16'h0009, 0, 0, 0, 0);
        chk("ninth_push_ignored_err", 16'(err), 16'h0);
        for (int i = 1; i <= 8; i++) begin
            chk("tx_drain_order", bif.D_pop, 16'(i));
            drive(0, 0, 1, 0, 0, 0);
        end
        chk("tx_empty_pndng", 16'(bif.pndng), 16'h0);
        chk("tx_empty_dpop", bif.D_pop, 16'h0);

        for (int i = 0; i < 8; i++) drive(1, 16'h0011 + 16'(i), 0, 0, 0, 0);
        drive(1, 16'hAAAA, 1, 0, 0, 0);
        chk("full_push_pop_tx_full", 16'(tx_full), 16'h1);
        chk("full_push_pop_head", bif.D_pop, 16'h0012);
        for (int i = 0; i < 8; i++) begin
            chk("tx_drain_after_swap", bif.D_pop, (i < 7) ? 16'h0012 + 16'(i) : 16'hAAAA);
            drive(0, 0, 1, 0, 0, 0);
        end

        drive(0, 0, 1, 0, 0, 0);
        chk("err_on_empty_pop", 16'(err), 16'h1);
        drive(0, 0, 0, 0, 0, 0);
        chk("err_sticky", 16'(err), 16'h1);

        drive(0, 0, 0, 1, 16'h03CD, 0);
        drive(0, 0, 0, 1, 16'hFF12, 0);
        drive(0, 0, 0, 1, 16'h0599, 0);
        chk("filter_no_drop_count", 16'(rx_drops), 16'h0);
        chk("rx_head_own_id", host_rdata, 16'h03CD);
        drive(0, 0, 0, 0, 0, 1);
        chk("rx_head_broadcast", host_rdata, 16'hFF12);
        drive(0, 0, 0, 0, 0, 1);
        chk("rx_empty_after_filter", 16'(rx_empty), 16'h1);

        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 16'h0300 + 16'(i), 0);
        chk("rx_overflow_drops", 16'(rx_drops), 16'h2);
        for (int i = 0; i < 4; i++) begin
            chk("rx_pop_order", host_rdata, 16'h0300 + 16'(i));
            drive(0, 0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 16'h0310 + 16'(i), 0);
        drive(0, 0, 0, 1, 16'h03EE, 1);
        drive(0, 0, 0, 1, 16'h0599, 0);
        chk("rx_full_pop_push_no_drop", 16'(rx_drops), 16'h2);
        for (int i = 0; i < 8; i++) begin
            chk("rx_wrap_order", host_rdata,
                (i < 3) ? 16'h0305 + 16'(i) : (i < 7) ? 16'h0310 + 16'(i - 3) : 16'h03EE);
            drive(0, 0, 0, 0, 0, 1);
        end

        for (int i = 0; i < 4; i++) drive(1, 16'h5000 + 16'(i), 0, 1, 16'h0340 + 16'(i), 0);
        chk("half_full_tx_head", bif.D_pop, 16'h5000);
        reset = 1'b0;
        #1;
        chk("async_reset_pndng", 16'(bif.pndng), 16'h0);
        chk("async_reset_dpop", bif.D_pop, 16'h0);
        chk("async_reset_rdata", host_rdata, 16'h0);
        chk("async_reset_rx_empty", 16'(rx_empty), 16'h1);
        chk("async_reset_drops", 16'(rx_drops), 16'h0);
        chk("async_reset_err", 16'(err), 16'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("after_reset_empty", 16'(bif.pndng), 16'h0);
        @(negedge clk);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_dev_fifo.md
# bus_dev_fifo

Device-side endpoint of the bus generator/arbiter protocol: one instance per bus port, presenting a pending flag, first-word-fall-through data and a pop input to the bus, and accepting bus pushes. A local host queues outbound packets into a TX FIFO. Inbound bus packets are address-filtered into an RX FIFO the host drains. It is the synthesizable counterpart of the behavioural FIFO the bench driver emulates.

## Interface

- pckg_sz, 16: packet width in bits; bits [pckg_sz-1 -: 8] are the destination ID.
- depth, 8: entries per FIFO; power of two, at least 2.
- id, 0: this device's 8-bit address.
- broadcast, 8'hFF: destination ID accepted by every device.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; state clears immediately when low.
- pndng  out  1  TX FIFO not empty.
- D_pop  out  pckg_sz  TX head entry (FWFT); 0 when empty.
- pop  in  1  bus consumes the TX head.
- push  in  1  bus delivers D_push.
- D_push  in  pckg_sz  inbound packet.
- host_push  in  1  write host_wdata into TX.
- host_wdata  in  pckg_sz  outbound packet.
- tx_full  out  1  TX holds depth entries.
- host_pop  in  1  consume RX head.
- host_rdata  out  pckg_sz  RX head (FWFT); 0 when empty.
- rx_empty  out  1  RX holds no entries.
- rx_drops  out  8  count of inbound packets lost to RX overflow; saturates at 255.
- err  out  1  sticky: pop while TX empty, or host_pop while RX empty.

## Operation

- Two independent circular FIFOs. Each has read and write pointers of log2(depth) bits that wrap modulo depth, plus a count of log2(depth)+1 bits.
- TX write: host_push with tx_full=0 stores host_wdata at the write pointer.
- TX full case: host_push while full is accepted only if pop is asserted in the same cycle, so the count is unchanged. Otherwise the write is ignored with no error.
- TX read: pop with pndng=1 advances the read pointer. Pop with pndng=0 is ignored and sets err.
- RX accept filter: push is accepted only if D_push[pckg_sz-1 -: 8] equals id or equals broadcast. Other packets are silently discarded and are not counted.
- RX overflow: an accepted packet arriving while RX is full, with no host_pop in the same cycle, is dropped and increments rx_drops.
- RX full with host_pop: if host_pop is asserted in the same cycle, the accepted packet is stored.
- RX read: host_pop with rx_empty=0 advances the RX pointer. host_pop with rx_empty=1 is ignored and sets err.
- Simultaneous read and write on the same FIFO: both take effect; the count is unchanged.
- Write into an empty FIFO with no read: the count goes to 1. The head becomes visible next cycle.
- Outputs are derived from registered state only; there is no combinational input-to-output path.

## Timing

- Reset low: all pointers, counts, rx_drops and err cleared asynchronously.
- Reset values: pndng=0, D_pop=0, tx_full=0, rx_empty=1, host_rdata=0, rx_drops=0, err=0.
- Reset release: operation resumes on the first rising edge after reset goes high.
- Reset mid-operation: FIFO contents are discarded.
- Write latency: data written at edge n appears on D_pop / host_rdata, and flags update, after edge n. It is visible in cycle n+1.
- Pop latency: pop at edge n presents the next entry (or 0 with pndng=0) after edge n.
- Bus-side back-to-back: pop every cycle is legal and drains one entry per cycle.
- Flags: tx_full, pndng and rx_empty are pure functions of the registered counts.

## Test plan

- Reset: hold reset low for 2 cycles with push and host_push active -> all outputs at reset values; nothing stored.
- TX fill/drain: 8 host_push of 16'h0001..16'h0008 -> tx_full=1 after the 8th. A 9th push with no pop is ignored. 8 pops return 0001..0008 in order, then pndng=0 and D_pop=0.
- Simultaneous access when full: TX full, host_push 16'hAAAA together with pop -> head advances, tx_full stays 1, and 16'hAAAA becomes the last entry.
- RX filter, with id=3: push 16'h03CD -> stored. Push 16'hFF12 -> stored. Push 16'h0599 -> discarded, rx_drops stays 0. host_rdata reads 03CD then FF12.
- RX overflow: 10 accepted pushes with no host_pop -> 8 stored, rx_drops=2. Wrap-around check: pop 4, push 4 -> order preserved.
- Error and reset mid-operation: pop with TX empty -> err=1 and stays 1. Assert reset with both FIFOs half full -> outputs clear immediately, before the next clock edge.
